// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, LSB first, with a one-entry holding register.
//
// Frame: start (0), 8 data bits LSB first, optional parity, STOP_BITS stop bits (1).
// A byte waiting in the holding register is launched on the last cycle of the current
// stop bit, so back-to-back frames go out with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between the data and
// stop bits (even parity when PARITY_ODD = 0, odd when PARITY_ODD = 1).
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       line rate in bits/s; DIV = CLK_FREQ / BAUD clocks per bit (must be >= 2)
//   STOP_BITS  1 or 2
//   PARITY_ODD parity sense when UART_TX_PARITY_EN is defined (0 or 1)
//
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   tx_data   byte to send, sampled on the handshake edge
//   tx_valid  tx_data is valid
//   tx_ready  holding register empty; byte accepted when tx_valid & tx_ready
//   tx        serial line, idle high, registered
//   tx_busy   frame in flight or holding register full
module uart_tx #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [2:0]       STOP_MAX = 3'(STOP_BITS - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx: STOP_BITS must be 1 or 2");
        end
        if (PARITY_ODD > 1) begin : g_bad_parity
            $error("uart_tx: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e           state_q;
    logic [7:0]       hold_q;
    logic             hold_full_q;
    logic [7:0]       shift_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;      // data bit index in StData, stop bit index in StStop
    logic             tx_q;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    logic bit_end;
    logic stop_end;
    logic load;

    assign bit_end  = (cnt_q == CNT_MAX);
    assign stop_end = (state_q == StStop) && bit_end && (idx_q == STOP_MAX);
    // Launch the held byte from idle, or seamlessly on the last cycle of the last stop bit.
    assign load     = hold_full_q && ((state_q == StIdle) || stop_end);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            // Accept never coincides with load: load needs hold_full, accept needs !hold_full.
            if (tx_valid && !hold_full_q) begin
                hold_q      <= tx_data;
                hold_full_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                end
                StStart: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == 3'd7) begin
                            idx_q   <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        idx_q   <= 3'd0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                StStop: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (idx_q == STOP_MAX) begin
                            state_q <= StIdle;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase

            // Overrides the case above on a launch edge.
            if (load) begin
                shift_q     <= hold_q;
                hold_full_q <= 1'b0;
                tx_q        <= 1'b0;
                cnt_q       <= '0;
                state_q     <= StStart;
`ifdef UART_TX_PARITY_EN
                parity_q    <= (^hold_q) ^ PARITY_ODD[0];
`endif
            end
        end
    end

    assign tx       = tx_q;
    assign tx_ready = !hold_full_q;
    assign tx_busy  = (state_q != StIdle) || hold_full_q;

endmodule
